// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Multi-cycle multiply/divide sequencer that owns the HI/LO write port of the
// writeback stage. It accepts one MULT/MULTU/DIV/DIVU request, stalls issue
// while a fixed-latency multiply or a 32-step restoring divide runs, then
// pulses the HI/LO write enables for one cycle.
//
// Parameters
//   MUL_STAGES      cycles spent in MUL before the result write (1..8)
//
// Ports
//   clk             system clock, all state on rising edge
//   rst             asynchronous, active-low reset
//   start           request valid from execute, sampled only in IDLE
//   op              00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a           rs operand (dividend / multiplicand)
//   src_b           rt operand (divisor / multiplier)
//   flush           cancel; aborts any operation and suppresses the write
//   busy            stall request to execute/issue (combinational)
//   write_hi        HI write enable, one-cycle pulse
//   write_lo        LO write enable, identical to write_hi
//   write_hi_value  product[63:32] / remainder
//   write_lo_value  product[31:0]  / quotient
//   done            identical to write_hi, releases the pipeline scoreboard
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MUL_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        write_hi,
    output logic        write_lo,
    output logic [31:0] write_hi_value,
    output logic [31:0] write_lo_value,
    output logic        done
);

    localparam logic [4:0] MUL_LOAD = 5'(MUL_STAGES - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic        accept;
    logic        load_res;
    logic        wr;

    logic [4:0]  cnt;
    logic        is_signed_q;
    logic [31:0] a_q, b_q;       // operands exactly as issued
    logic [31:0] dvd_q;          // dividend magnitude, shifts into quotient
    logic [31:0] dvs_q;          // divisor magnitude
    logic [31:0] rem_q;          // partial remainder (always < divisor)
    logic [31:0] hi_q, lo_q;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_n  = state;
        busy     = 1'b0;
        wr       = 1'b0;
        load_res = 1'b0;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    accept  = 1'b1;
                    busy    = 1'b1;   // stall the issuing instruction now
                    state_n = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (flush) begin
                    state_n = S_IDLE;
                end else if (cnt == 5'd0) begin
                    state_n  = S_DONE;
                    load_res = 1'b1;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (flush) begin
                    state_n = S_IDLE;
                end else if (cnt == DIV_LAST) begin
                    state_n  = S_DONE;
                    load_res = 1'b1;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                wr      = !flush;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: multiply
    // -------------------------------------------------------------------------
    logic [63:0] mul_a, mul_b, product;

    // A 64x64 product truncated to 64 bits is the correct two's-complement
    // result for both the sign-extended and zero-extended cases.
    assign mul_a   = {{32{is_signed_q & a_q[31]}}, a_q};
    assign mul_b   = {{32{is_signed_q & b_q[31]}}, b_q};
    assign product = mul_a * mul_b;

    // -------------------------------------------------------------------------
    // Datapath: one restoring-divide step
    // -------------------------------------------------------------------------
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_n, dvd_n;

    assign rem_shift = {rem_q, dvd_q[31]};
    assign rem_ge    = rem_shift >= {1'b0, dvs_q};
    // When the subtraction is taken the true difference is below the divisor,
    // so the low 32 bits are exact.
    assign rem_n     = rem_ge ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
    assign dvd_n     = {dvd_q[30:0], rem_ge};

    // -------------------------------------------------------------------------
    // Result formation (sampled on the last MUL/DIV cycle)
    // -------------------------------------------------------------------------
    logic        q_neg, r_neg;
    logic [31:0] res_hi, res_lo;

    assign q_neg = is_signed_q & (a_q[31] ^ b_q[31]);
    assign r_neg = is_signed_q & a_q[31];

    always_comb begin
        res_hi = product[63:32];
        res_lo = product[31:0];
        if (state == S_DIV) begin
            if (dvs_q == 32'd0) begin
                res_hi = a_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = r_neg ? -rem_n : rem_n;
                res_lo = q_neg ? -dvd_n : dvd_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= 5'd0;
            is_signed_q <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            dvd_q       <= 32'd0;
            dvs_q       <= 32'd0;
            rem_q       <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            if (accept) begin
                is_signed_q <= ~op[0];
                a_q         <= src_a;
                b_q         <= src_b;
                dvd_q       <= (~op[0] & src_a[31]) ? -src_a : src_a;
                dvs_q       <= (~op[0] & src_b[31]) ? -src_b : src_b;
                rem_q       <= 32'd0;
                cnt         <= op[1] ? 5'd0 : MUL_LOAD;
            end else if (state == S_MUL) begin
                cnt <= cnt - 5'd1;
            end else if (state == S_DIV) begin
                dvd_q <= dvd_n;
                rem_q <= rem_n;
                cnt   <= cnt + 5'd1;
            end
            if (load_res) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign write_hi       = wr;
    assign write_lo       = wr;
    assign done           = wr;
    assign write_hi_value = hi_q;
    assign write_lo_value = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Self-checking bench for muldiv_ctrl. Expected results come from plain
// 64-bit arithmetic on the operands; cycle positions come from the stated
// latencies (MUL_STAGES for multiply, 32 for divide).
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam int MUL_STAGES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        busy, write_hi, write_lo, done;
    logic [31:0] write_hi_value, write_lo_value;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;
    bit          vals_known = 1'b1;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_STAGES(MUL_STAGES)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op             (op),
        .src_a          (src_a),
        .src_b          (src_b),
        .flush          (flush),
        .busy           (busy),
        .write_hi       (write_hi),
        .write_lo       (write_lo),
        .write_hi_value (write_hi_value),
        .write_lo_value (write_lo_value),
        .done           (done)
    );

    // Reference: MIPS HI/LO semantics from plain arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (o[0] == 1'b0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (!o[1]) begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = 32'(r);
            lo = 32'(q);
        end
    endfunction

    // Idle-cycle observation: no stall, no write, values retained.
    task automatic check_idle(input string nm);
        checks++;
        if (busy !== 1'b0 || write_hi !== 1'b0 || write_lo !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b wr_hi=%b wr_lo=%b done=%b, required all 0",
                     nm, busy, write_hi, write_lo, done);
        end
        if (vals_known) begin
            checks++;
            if (write_hi_value !== last_hi || write_lo_value !== last_lo) begin
                errors++;
                $display("FAIL %s held: hi=%h lo=%h, required hi=%h lo=%h",
                         nm, write_hi_value, write_lo_value, last_hi, last_lo);
            end
        end
    endtask

    // Issue one operation in the next cycle and follow it to completion.
    // Calling this twice in a row issues back-to-back in the cycle after DONE.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, b, input string nm);
        int lat;
        logic [31:0] ehi, elo;
        lat = o[1] ? 32 : MUL_STAGES;
        model(o, a, b, ehi, elo);

        @(negedge clk);
        check_idle({nm, " pre"});
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept-busy: busy=%b, required 1", nm, busy);
        end
        @(posedge clk);
        #1 start = 1'b0;

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || write_hi !== (k == lat + 1) ||
                write_lo !== write_hi || done !== write_hi) begin
                errors++;
                $display("FAIL %s cycle T+%0d: busy=%b wr_hi=%b wr_lo=%b done=%b, required busy=1 wr=%b",
                         nm, k, busy, write_hi, write_lo, done, (k == lat + 1));
            end
        end
        checks++;
        if (write_hi_value !== ehi || write_lo_value !== elo) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h",
                     nm, write_hi_value, write_lo_value, ehi, elo);
        end
        last_hi    = ehi;
        last_lo    = elo;
        vals_known = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || write_hi !== 1'b0 || write_lo !== 1'b0 || done !== 1'b0 ||
            write_hi_value !== 32'd0 || write_lo_value !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b wr=%b hi=%h lo=%h, required all zero",
                     busy, write_hi, write_hi_value, write_lo_value);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_hi = 32'd0; last_lo = 32'd0; vals_known = 1'b1;
    endtask

    task automatic test_mul();
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min");
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_op(2'b11, 32'd100, 32'd7, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, "divu_b2b");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_pos_neg");
    endtask

    task automatic test_div_zero();
        run_op(2'b11, 32'd5, 32'd0, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, "div_by0");
    endtask

    task automatic test_flush_running();
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);          // cycle T+10
        flush = 1'b1;
        #1;
        checks++;
        if (write_hi !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_div T+10: wr=%b busy=%b, required wr=0 busy=1", write_hi, busy);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        for (int k = 11; k <= 45; k++) begin
            @(negedge clk);
            check_idle("flush_div after");
        end
    endtask

    task automatic test_flush_done();
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (MUL_STAGES + 1) @(negedge clk);   // DONE cycle
        flush = 1'b1;
        #1;
        checks++;
        if (write_hi !== 1'b0 || write_lo !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: wr_hi=%b wr_lo=%b done=%b, required 0",
                     write_hi, write_lo, done);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        vals_known = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("flush_done after");
        end
    endtask

    task automatic test_flush_start();
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd3;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_start busy: busy=%b, required 0", busy);
        end
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check_idle("flush_start after");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);          // cycle T+20
        #1 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || write_hi !== 1'b0 || done !== 1'b0 ||
            write_hi_value !== 32'd0 || write_lo_value !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b wr=%b hi=%h lo=%h, required all zero",
                     busy, write_hi, write_hi_value, write_lo_value);
        end
        @(negedge clk);
        rst = 1'b1;
        last_hi = 32'd0; last_lo = 32'd0; vals_known = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check_idle("post_reset");
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(o, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush_running();
        test_flush_done();
        test_flush_start();
        test_async_reset();
        test_random();
        @(negedge clk);
        check_idle("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
